// File: rtl/xy2_frame_sched.sv
`default_nettype none
// ============================================================================
// Module : xy2_frame_sched
// Desc   : XY2-100 frame scheduler - point FIFO, frame timer, launch FSM.
//          Define XY2_HOLD_LAST_EN to resend the last point on FIFO underflow.
// Rev    : 1.0
// ============================================================================
module xy2_frame_sched #(
  parameter int DEPTH       = 16,
  parameter int FRAME_CYC   = 600,
  parameter int TIMEOUT_CYC = 1200,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clk50m,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          wr_en,
  input  logic [15:0]   wr_x,
  input  logic [15:0]   wr_y,
  input  logic          clr_flags,
  input  logic          txdone,
  output logic          send_en,
  output logic [15:0]   x_data,
  output logic [15:0]   y_data,
  output logic          busy,
  output logic [AW:0]   fifo_level,
  output logic          full,
  output logic          empty,
  output logic          underflow,
  output logic          overrun,
  output logic          overflow,
  output logic          timeout,
  output logic [15:0]   frame_cnt
);

  localparam int TW = $clog2(FRAME_CYC);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] c_timer_last = TW'(FRAME_CYC - 1);
  localparam logic [CW-1:0] c_to_last    = CW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   c_depth      = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_to_cnt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_mem [DEPTH];

  logic w_tick;
  logic w_push;
  logic w_pop;
  logic w_empty_tick;
  logic w_relaunch;
  logic w_set_timeout;

  assign w_tick        = enable && (r_timer == c_timer_last);
  assign full          = (fifo_level == c_depth);
  assign empty         = (fifo_level == '0);
  assign busy          = (r_state != ARMED);
  assign w_push        = wr_en && !full;
  assign w_pop         = w_tick && (r_state == ARMED) && !empty;
  assign w_empty_tick  = w_tick && (r_state == ARMED) && empty;
  assign w_set_timeout = (r_state == WAIT_DONE) && !txdone && (r_to_cnt == c_to_last);

`ifdef XY2_HOLD_LAST_EN
  logic r_launched;

  // Relaunch is only meaningful once x_data/y_data hold a real point.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n)
      r_launched <= 1'b0;
    else if (w_pop)
      r_launched <= 1'b1;
  end

  assign w_relaunch = w_empty_tick && r_launched;
`else
  assign w_relaunch = 1'b0;
`endif

  // Parked at the last count while disabled so the first enabled cycle ticks.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n)
      r_timer <= c_timer_last;
    else if (!enable)
      r_timer <= c_timer_last;
    else if (r_timer == c_timer_last)
      r_timer <= '0;
    else
      r_timer <= r_timer + 1'b1;
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fifo_level <= '0;
      r_mem      <= '{default: '0};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {wr_x, wr_y};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        fifo_level <= fifo_level + 1'b1;
      else if (!w_push && w_pop)
        fifo_level <= fifo_level - 1'b1;
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARMED;
      send_en   <= 1'b0;
      x_data    <= '0;
      y_data    <= '0;
      r_to_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      send_en <= 1'b0;
      case (r_state)
        ARMED: begin
          if (w_pop) begin
            {x_data, y_data} <= r_mem[r_rd_ptr];
            send_en          <= 1'b1;
            r_state          <= SEND;
          end else if (w_relaunch) begin
            send_en <= 1'b1;
            r_state <= SEND;
          end
        end
        SEND: begin
          r_to_cnt <= '0;
          r_state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (txdone) begin
            frame_cnt <= frame_cnt + 1'b1;
            r_state   <= ARMED;
          end else if (r_to_cnt == c_to_last) begin
            r_state <= ARMED;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= ARMED;
      endcase
    end
  end

  // A set condition in the same cycle as clr_flags takes priority.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
      overrun   <= 1'b0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      underflow <= (underflow && !clr_flags) || w_empty_tick;
      overrun   <= (overrun   && !clr_flags) || (w_tick && busy);
      overflow  <= (overflow  && !clr_flags) || (wr_en && full);
      timeout   <= (timeout   && !clr_flags) || w_set_timeout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xy2_frame_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_xy2_frame_sched
// Desc   : Randomized point streams checked against a queue-based frame model.
// Rev    : 1.0
// ============================================================================
module tb_xy2_frame_sched;

  localparam int DEPTH       = 16;
  localparam int FRAME_CYC   = 600;
  localparam int TIMEOUT_CYC = 1200;

  logic        clk50m    = 1'b0;
  logic        rst_n     = 1'b0;
  logic        enable    = 1'b0;
  logic        wr_en     = 1'b0;
  logic [15:0] wr_x      = '0;
  logic [15:0] wr_y      = '0;
  logic        clr_flags = 1'b0;
  logic        txdone    = 1'b0;
  logic        send_en, busy, full, empty;
  logic        underflow, overrun, overflow, timeout;
  logic [15:0] x_data, y_data, frame_cnt;
  logic [4:0]  fifo_level;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] model_q[$];
  logic [31:0] last_sent = '0;
  logic [15:0] exp_frames = '0;
  int          last_send_cyc = 0;

  xy2_frame_sched #(
    .DEPTH       (DEPTH),
    .FRAME_CYC   (FRAME_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk50m     (clk50m),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .clr_flags  (clr_flags),
    .txdone     (txdone),
    .send_en    (send_en),
    .x_data     (x_data),
    .y_data     (y_data),
    .busy       (busy),
    .fifo_level (fifo_level),
    .full       (full),
    .empty      (empty),
    .underflow  (underflow),
    .overrun    (overrun),
    .overflow   (overflow),
    .timeout    (timeout),
    .frame_cnt  (frame_cnt)
  );

  always #10 clk50m = ~clk50m;
  always @(posedge clk50m) cyc <= cyc + 1;

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk50m);
  endtask

  task automatic push(input logic [31:0] p);
    wr_x  = p[31:16];
    wr_y  = p[15:0];
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_txdone();
    txdone = 1'b1;
    step();
    txdone = 1'b0;
  endtask

  task automatic wait_send(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (send_en === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    checks++;
    if ({send_en, busy, full, empty, underflow, overrun, overflow, timeout} !== 8'b0001_0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00010000",
               {send_en, busy, full, empty, underflow, overrun, overflow, timeout});
    end
    checks++;
    if ({x_data, y_data, frame_cnt, fifo_level} !== '0) begin
      errors++;
      $display("FAIL reset_data: got x=%h y=%h cnt=%h lvl=%0d expected all zero",
               x_data, y_data, frame_cnt, fifo_level);
    end
    rst_n = 1'b1;
    step();
    pulse_txdone();
    checks++;
    if (frame_cnt !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_txdone: got cnt=%0d busy=%b expected 0 0", frame_cnt, busy);
    end
  endtask

  task automatic test_first_frame();
    logic [31:0] p;
    p = 32'h1234_ABCD;
    push(p);
    model_q.push_back(p);
    checks++;
    if (fifo_level !== 5'd1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL first_level: got lvl=%0d empty=%b expected 1 0", fifo_level, empty);
    end
    enable = 1'b1;
    step();
    checks++;
    if (send_en !== 1'b1 || {x_data, y_data} !== model_q[0]) begin
      errors++;
      $display("FAIL first_send: got send_en=%b xy=%h expected 1 %h", send_en, {x_data, y_data}, model_q[0]);
    end
    last_sent     = model_q.pop_front();
    last_send_cyc = cyc;
    step(519);
    pulse_txdone();
    exp_frames++;
    checks++;
    if (frame_cnt !== exp_frames || busy !== 1'b0) begin
      errors++;
      $display("FAIL first_done: got cnt=%0d busy=%b expected %0d 0", frame_cnt, busy, exp_frames);
    end
  endtask

  task automatic test_stream();
    int          n;
    bit          found;
    logic [31:0] p;
    n = 3 + $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      p = $urandom;
      push(p);
      model_q.push_back(p);
    end
    checks++;
    if (fifo_level !== 5'(n)) begin
      errors++;
      $display("FAIL stream_level: got %0d expected %0d", fifo_level, n);
    end
    while (model_q.size() > 0) begin
      wait_send(FRAME_CYC + 5, found);
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL stream_send: got no send_en expected one within %0d cycles", FRAME_CYC + 5);
        break;
      end
      p = model_q.pop_front();
      checks++;
      if ({x_data, y_data} !== p) begin
        errors++;
        $display("FAIL stream_data: got %h expected %h", {x_data, y_data}, p);
      end
      checks++;
      if (cyc - last_send_cyc != FRAME_CYC) begin
        errors++;
        $display("FAIL stream_period: got %0d expected %0d", cyc - last_send_cyc, FRAME_CYC);
      end
      checks++;
      if (fifo_level !== 5'(model_q.size()) || empty !== (model_q.size() == 0)) begin
        errors++;
        $display("FAIL stream_occupancy: got lvl=%0d empty=%b expected %0d %b",
                 fifo_level, empty, model_q.size(), model_q.size() == 0);
      end
      last_send_cyc = cyc;
      last_sent     = p;
      step($urandom_range(2, 560));
      pulse_txdone();
      exp_frames++;
      checks++;
      if (frame_cnt !== exp_frames) begin
        errors++;
        $display("FAIL stream_frames: got %0d expected %0d", frame_cnt, exp_frames);
      end
    end
  endtask

  task automatic test_empty_tick();
    bit found;
    wait_send(FRAME_CYC + 5, found);
`ifdef XY2_HOLD_LAST_EN
    checks++;
    if (!found || {x_data, y_data} !== last_sent) begin
      errors++;
      $display("FAIL hold_last: got found=%b xy=%h expected 1 %h", found, {x_data, y_data}, last_sent);
    end
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL hold_underflow: got %b expected 1", underflow);
    end
    step(10);
    pulse_txdone();
    exp_frames++;
`else
    checks++;
    if (found) begin
      errors++;
      $display("FAIL empty_no_send: got send_en with xy=%h expected none", {x_data, y_data});
    end
    checks++;
    if (underflow !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_underflow: got uf=%b busy=%b expected 1 0", underflow, busy);
    end
`endif
  endtask

  task automatic test_timeout_overrun();
    logic [31:0] p;
    enable    = 1'b0;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    checks++;
    if ({underflow, overrun, overflow, timeout} !== 4'b0) begin
      errors++;
      $display("FAIL clr_before_timeout: got %b expected 0000", {underflow, overrun, overflow, timeout});
    end
    p = $urandom;
    push(p);
    enable = 1'b1;
    step();
    checks++;
    if (send_en !== 1'b1 || {x_data, y_data} !== p) begin
      errors++;
      $display("FAIL timeout_launch: got send_en=%b xy=%h expected 1 %h", send_en, {x_data, y_data}, p);
    end
    last_sent = p;
    step(595);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_early: got %b expected 0", overrun);
    end
    step(10);
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got ovr=%b busy=%b expected 1 1", overrun, busy);
    end
    step(590);
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got to=%b busy=%b expected 0 1", timeout, busy);
    end
    step(7);
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL timeout_set: got to=%b busy=%b cnt=%0d expected 1 0 %0d",
               timeout, busy, frame_cnt, exp_frames);
    end
    enable = 1'b0;
    step();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    checks++;
    if ({underflow, overrun, overflow, timeout} !== 4'b0) begin
      errors++;
      $display("FAIL clr_flags: got %b expected 0000", {underflow, overrun, overflow, timeout});
    end
  endtask

  task automatic test_overflow();
    bit          found;
    logic [31:0] p;
    for (int i = 0; i < DEPTH; i++) begin
      p = $urandom;
      push(p);
      model_q.push_back(p);
    end
    checks++;
    if (full !== 1'b1 || fifo_level !== 5'(DEPTH)) begin
      errors++;
      $display("FAIL fill: got full=%b lvl=%0d expected 1 %0d", full, fifo_level, DEPTH);
    end
    push(32'hDEAD_BEEF);
    checks++;
    if (overflow !== 1'b1 || fifo_level !== 5'(DEPTH)) begin
      errors++;
      $display("FAIL overflow: got ovf=%b lvl=%0d expected 1 %0d", overflow, fifo_level, DEPTH);
    end
    clr_flags = 1'b1;
    wr_en     = 1'b1;
    step();
    clr_flags = 1'b0;
    wr_en     = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear: got %b expected 1", overflow);
    end
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_overflow: got %b expected 0", overflow);
    end
    enable = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wait_send(FRAME_CYC + 5, found);
      p = model_q.pop_front();
      checks++;
      if (!found || {x_data, y_data} !== p) begin
        errors++;
        $display("FAIL drain_%0d: got found=%b xy=%h expected 1 %h", i, found, {x_data, y_data}, p);
        break;
      end
      if (i > 0) begin
        checks++;
        if (cyc - last_send_cyc != FRAME_CYC) begin
          errors++;
          $display("FAIL drain_period: got %0d expected %0d", cyc - last_send_cyc, FRAME_CYC);
        end
      end
      last_send_cyc = cyc;
      last_sent     = p;
      step($urandom_range(2, 500));
      pulse_txdone();
      exp_frames++;
    end
    checks++;
    if (empty !== 1'b1 || frame_cnt !== exp_frames) begin
      errors++;
      $display("FAIL drain_end: got empty=%b cnt=%0d expected 1 %0d", empty, frame_cnt, exp_frames);
    end
    wait_send(FRAME_CYC + 5, found);
`ifdef XY2_HOLD_LAST_EN
    checks++;
    if (!found || {x_data, y_data} !== last_sent) begin
      errors++;
      $display("FAIL no_17th: got found=%b xy=%h expected 1 %h", found, {x_data, y_data}, last_sent);
    end
    step(10);
    pulse_txdone();
    exp_frames++;
`else
    checks++;
    if (found) begin
      errors++;
      $display("FAIL no_17th: got send_en with xy=%h expected none", {x_data, y_data});
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    bit          found;
    logic [31:0] p;
    p = $urandom;
    push(p);
    wait_send(FRAME_CYC + 5, found);
    checks++;
    if (!found || {x_data, y_data} !== p) begin
      errors++;
      $display("FAIL mid_launch: got found=%b xy=%h expected 1 %h", found, {x_data, y_data}, p);
    end
    step(101);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({send_en, busy, full, empty, underflow, overrun, overflow, timeout} !== 8'b0001_0000
        || {x_data, y_data, frame_cnt, fifo_level} !== '0) begin
      errors++;
      $display("FAIL async_reset: got flags=%b x=%h y=%h cnt=%0d lvl=%0d expected 00010000 and zeros",
               {send_en, busy, full, empty, underflow, overrun, overflow, timeout},
               x_data, y_data, frame_cnt, fifo_level);
    end
    enable = 1'b0;
    step(2);
    rst_n = 1'b1;
    step();
    p = $urandom;
    push(p);
    enable = 1'b1;
    step();
    checks++;
    if (send_en !== 1'b1 || {x_data, y_data} !== p || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL post_reset_launch: got send_en=%b xy=%h cnt=%0d expected 1 %h 0",
               send_en, {x_data, y_data}, frame_cnt, p);
    end
    step(300);
    pulse_txdone();
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL post_reset_done: got %0d expected 1", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_stream();
    test_empty_tick();
    test_timeout_overrun();
    test_overflow();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
